// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx                                                       |
// | Purpose  : 8N1 UART receiver (LSB first, idle-high line), one-cycle      |
// |            valid/frame-error strobes, waits out line breaks.             |
// |            Optional even parity bit when UART_RX_PARITY_EN is defined.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter int TICKS_PER_BIT = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic       parity_err_o
);

  localparam int                  c_TICK_W    = $clog2(TICKS_PER_BIT);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(TICKS_PER_BIT / 2 - 1);

  generate
    if (TICKS_PER_BIT < 4 || (TICKS_PER_BIT % 2) != 0) begin : g_bad_param
      $error("uart_rx: TICKS_PER_BIT must be even and >= 4");
    end
  endgenerate

`ifdef UART_RX_PARITY_EN
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_START  = 6'b000010,
    S_DATA   = 6'b000100,
    S_PARITY = 6'b001000,
    S_STOP   = 6'b010000,
    S_BREAK  = 6'b100000
  } state_t;
`else
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_STOP   = 5'b01000,
    S_BREAK  = 5'b10000
  } state_t;
`endif

  state_t              r_state;
  logic [c_TICK_W-1:0] r_tick;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [1:0]          r_sync;
  logic [7:0]          r_data;
  logic                r_valid;
  logic                r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                r_parity_err;
  logic                r_par_bad;
`endif

  logic w_rx_s;
  logic w_tick_last;

  assign w_rx_s      = r_sync[1];
  assign w_tick_last = (r_tick == c_TICK_LAST);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
      r_par_bad    <= 1'b0;
`endif
    end else begin
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_tick  <= '0;
          end
        end
        S_START: begin
          // Re-check the line half a bit in; a high here was only a glitch.
          if (r_tick == c_TICK_MID) begin
            r_tick <= '0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick_last) begin
            r_tick    <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick_last) begin
            r_tick    <= '0;
            r_par_bad <= (^r_shift) ^ w_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_tick_last) begin
            r_tick <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
`else
              r_data  <= r_shift;
              r_valid <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_BREAK: begin
          // Hold here while the line stays low so a break is not decoded as 0x00.
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
        end
      endcase
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign busy_o      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = r_parity_err;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Self-checking bench for uart_rx: frames are generated from a byte list and
// the expected strobe cycle of each frame is queued from bit-time arithmetic.
module tb_uart_rx;

  localparam int TPB  = 16;
  localparam int HALF = TPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB     = 10;
  localparam bit PAR_EN = 1'b1;
  localparam int LAT    = 171;
`else
  localparam int NB     = 9;
  localparam bit PAR_EN = 1'b0;
  localparam int LAT    = 155;
`endif
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, busy_o, parity_err_o;

  uart_rx #(.TICKS_PER_BIT(TPB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         t_valid = 0;
  logic [7:0] exp_data = 8'h00;
  logic       checking = 1'b0;
  logic       e_v, e_f, e_p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Cycle-by-cycle comparison against the queued expectations.
  always @(negedge clk) begin
    if (checking) begin
      e_v = 1'b0; e_f = 1'b0; e_p = 1'b0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        case (evq[0].kind)
          K_VALID: begin e_v = 1'b1; exp_data = evq[0].d; end
          K_FERR:  e_f = 1'b1;
          default: e_p = 1'b1;
        endcase
        void'(evq.pop_front());
      end
      chk("valid_o", {31'd0, valid_o}, {31'd0, e_v});
      chk("frame_err_o", {31'd0, frame_err_o}, {31'd0, e_f});
      chk("parity_err_o", {31'd0, parity_err_o}, {31'd0, e_p});
      chk("data_o", {24'd0, data_o}, {24'd0, exp_data});
      if (valid_o) begin n_valid++; t_valid = cyc; end
      if (frame_err_o) n_ferr++;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (TPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; the start bit begins at the next edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, output int k);
    ev_t e;
    k     = cyc;
    e.cyc = k + 3 + HALF + NB * TPB;
    e.d   = d;
    if (!stop)                     e.kind = K_FERR;
    else if (PAR_EN && (^d ^ par)) e.kind = K_PERR;
    else                           e.kind = K_VALID;
    evq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
  endtask

  int         k0, n0, f0, gap;
  logic [7:0] rb;
  logic       rs, rp;

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset_data", {24'd0, data_o}, 32'h0);
    chk("reset_valid", {31'd0, valid_o}, 32'h0);
    chk("reset_busy", {31'd0, busy_o}, 32'h0);
    chk("reset_ferr", {31'd0, frame_err_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    checking = 1'b1;
    idle(TPB);

    // Single frame, latency pinned to a hand-computed value.
    n0 = n_valid;
    send_frame(8'hA5, 1'b1, 1'b0, k0);
    idle(2 * TPB);
    chk("a5_data", {24'd0, data_o}, 32'hA5);
    chk("a5_pulses", n_valid - n0, 1);
    chk("a5_latency", t_valid - k0, LAT);
    chk("a5_busy_after", {31'd0, busy_o}, 32'h0);

    // Back-to-back frames with no gap.
    n0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b0, k0);
    send_frame(8'hFF, 1'b1, 1'b1, k0);
    send_frame(8'h3C, 1'b1, 1'b0, k0);
    idle(2 * TPB);
    chk("b2b_count", n_valid - n0, 3);
    chk("b2b_last", {24'd0, data_o}, 32'h3C);

    // Short glitch shorter than half a bit.
    n0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    chk("glitch_busy_mid", {31'd0, busy_o}, 32'h1);
    idle(TPB);
    chk("glitch_busy_after", {31'd0, busy_o}, 32'h0);
    chk("glitch_no_pulse", (n_valid - n0) + (n_ferr - f0), 0);

    // Framing error followed by a long break.
    n0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0, k0);
    rx = 1'b0;
    repeat (40 * TPB) @(posedge clk);
    #1;
    chk("break_busy", {31'd0, busy_o}, 32'h1);
    idle(TPB);
    chk("break_ferr_count", n_ferr - f0, 1);
    chk("break_no_valid", n_valid - n0, 0);
    chk("break_hold_data", {24'd0, data_o}, 32'h3C);
    send_frame(8'h81, 1'b1, 1'b0, k0);
    idle(TPB);
    chk("after_break_data", {24'd0, data_o}, 32'h81);

    // Asynchronous reset in the middle of the data bits of 0xC3.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rb_c3(i));
    chk("busy_mid_frame", {31'd0, busy_o}, 32'h1);
    #2;
    rst = 1'b1;
    checking = 1'b0;
    evq.delete();
    exp_data = 8'h00;
    #1;
    chk("arst_data", {24'd0, data_o}, 32'h0);
    chk("arst_busy", {31'd0, busy_o}, 32'h0);
    chk("arst_valid", {31'd0, valid_o}, 32'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
    idle(TPB);
    send_frame(8'h7E, 1'b1, 1'b0, k0);
    idle(TPB);
    chk("after_reset_data", {24'd0, data_o}, 32'h7E);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0, k0);
    idle(TPB);
    chk("parity_bad_hold", {24'd0, data_o}, 32'h7E);
    send_frame(8'h01, 1'b1, 1'b1, k0);
    idle(TPB);
    chk("parity_good_data", {24'd0, data_o}, 32'h01);
`endif

    // Randomized frames with random gaps and occasional bad stop/parity bits.
    for (int n = 0; n < 14; n++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 5) != 0);
      rp  = ^rb;
      if ($urandom_range(0, 4) == 0) rp = ~rp;
      send_frame(rb, rs, rp, k0);
      gap = rs ? int'($urandom_range(0, 30)) : int'($urandom_range(4, 30));
      idle(gap);
    end
    idle(3 * TPB);
    chk("queue_drained", evq.size(), 0);
    chk("final_idle", {31'd0, busy_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic rb_c3(input int i);
    logic [7:0] v;
    v = 8'hC3;
    return v[i];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver: 8N1 frames, LSB first, line idles high. Counterpart to the team's uart_tx, using the same TICKS_PER_BIT bit timing.
- Sits between the external RX pin and the peripheral register block.
- Delivers each received byte with a one-cycle valid strobe.
- Reports framing errors and waits out line breaks.

Parameters:
- TICKS_PER_BIT, 32, clk_i cycles per bit. Legal range is ≥4 and even.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- rx_i  input  1  serial line, asynchronous to clk_i
- data_o  output  8  last good received byte, held until the next good frame
- valid_o  output  1  one-cycle pulse when data_o is updated
- frame_err_o  output  1  one-cycle pulse when the stop bit samples 0
- busy_o  output  1  high in every state except IDLE
- parity_err_o  output  1  one-cycle pulse on parity mismatch (tied 0 unless UART_RX_PARITY_EN)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high; every flop clears on rst_i rising with no clock.
- Reset values:
  - data_o=0, valid_o=0, frame_err_o=0, parity_err_o=0, busy_o=0.
  - state=IDLE, tick counter=0, bit counter=0, shift register=0.
  - Synchronizer flops reset to 1 (idle line).
- Input sync: rx_i passes through 2 flops giving rx_s. All decisions use rx_s, so there are 2 cycles of input latency.
- Tick counter: width $clog2(TICKS_PER_BIT). Cleared on every state entry. Wraps at TICKS_PER_BIT-1.
- State machine (one-hot): IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: when rx_s==0, go to START.
  - START: at tick==TICKS_PER_BIT/2-1 (mid start bit):
    - rx_s==0: go to DATA, bit counter=0, tick counter cleared. Every later sample then falls mid-bit.
    - rx_s==1: glitch. Return to IDLE with no output pulse.
  - DATA:
    - At tick==TICKS_PER_BIT-1, shift register becomes {rx_s, shift[7:1]} (LSB first) and the bit counter increments.
    - After the 8th sample, go to PARITY if enabled, else STOP.
  - STOP, at tick==TICKS_PER_BIT-1:
    - rx_s==1: next cycle data_o<=shift and valid_o=1 for exactly one cycle; go to IDLE.
    - rx_s==0: next cycle frame_err_o=1 for one cycle; data_o unchanged; go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- Latency: valid_o rises at about 9.5 bit-times plus 3 cycles after the start-bit falling edge on rx_i.
- Back-to-back frames: a start edge in the cycle after the STOP sample is accepted. There is no dead time beyond the half stop bit.
- Pulses: valid_o and frame_err_o are mutually exclusive. Neither is ever asserted for more than 1 cycle.
- No flow control: data_o is overwritten by the next good frame regardless of whether the consumer has read it.
- Reset mid-frame: returns to IDLE at once and no pulse is emitted. A frame already in progress on rx_i after reset release resyncs on the next falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - After DATA, the PARITY state samples one extra bit at tick==TICKS_PER_BIT-1 and expects even parity: XOR of 8 data bits plus the parity bit equals 0.
  - On mismatch, with a good stop bit: parity_err_o pulses for one cycle in the same cycle valid_o would pulse; valid_o stays 0 and data_o is unchanged.
  - A framing error takes precedence: frame_err_o only.
- Undefined: no PARITY state, parity_err_o tied 0, 8N1 only.

Test Plan:
- TICKS_PER_BIT=16, reset, rx_i=1, send 0xA5 (8N1) → valid_o one-cycle pulse, data_o=0xA5, frame_err_o never high, busy_o low after the frame.
- Send 0x00, 0xFF, 0x3C back-to-back with 1 stop bit each → three valid_o pulses, data_o=0x00/0xFF/0x3C in order.
- rx_i low for 5 cycles (< half bit) then high → no pulse, state returns to IDLE, busy_o falls.
- Send 0x55 with stop bit driven 0, then hold rx_i low for 40 bit-times, then release → exactly one frame_err_o pulse, data_o keeps its previous value, no further pulses until a new frame; a following 0x81 is received correctly.
- Assert rst_i asynchronously mid-DATA of 0xC3 → all outputs 0 immediately without a clock edge; the next full 0x7E frame after release is received correctly.
- With UART_RX_PARITY_EN, send 0x01 with parity bit 0 → parity_err_o pulse, no valid_o, data_o unchanged. Send 0x01 with parity bit 1 → valid_o pulse, data_o=0x01.
